adc_capture_ctrl: RTL and testbench
===================================

# adc_capture_ctrl

Sequencer for the ADC sample stream. It arms on a software request, waits a holdoff, then detects a level trigger or a forced trigger. It captures a programmed number of optionally decimated samples into an AXI4-Stream master that feeds the DMA writer, and reports state, peak, count and overflow to the status register bank. It sits between the ADC front-end stream and the DMA, and is configured from the AXI-lite config register bank.

## Interface
- DATA_WIDTH, 16, sample width on input and output streams
- CNT_WIDTH, 24, width of holdoff, length and sample counters
- aclk  in  1  system clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- cfg_arm  in  1  one-cycle arm request
- cfg_abort  in  1  one-cycle abort request
- cfg_force  in  1  one-cycle forced trigger
- cfg_level  in  DATA_WIDTH  trigger threshold, unsigned
- cfg_holdoff  in  CNT_WIDTH  input samples discarded after arm before trigger is enabled
- cfg_length  in  CNT_WIDTH  samples to capture; 0 treated as 1
- cfg_decim  in  8  keep 1 of (cfg_decim+1) input samples during capture
- s_axis_tvalid  in  1  input sample strobe; no backpressure
- s_axis_tdata  in  DATA_WIDTH  input sample, unsigned
- m_axis_tready  in  1  DMA ready
- m_axis_tvalid  out  1  output beat valid
- m_axis_tdata  out  DATA_WIDTH  captured sample
- m_axis_tlast  out  1  marks the final captured sample
- sts_state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- sts_peak  out  DATA_WIDTH  maximum captured sample since last arm
- sts_count  out  CNT_WIDTH  beats accepted by the DMA since last arm
- sts_overflow  out  1  sticky; a kept sample was dropped because the output register was full
- irq_done  out  1  one-cycle pulse on entry to DONE

## Operation
- The single output register holds at most one beat.
- A beat transfers when m_axis_tvalid and m_axis_tready are both high.
- IDLE or DONE, cfg_arm=1 -> ARMED.
  - cfg_holdoff, cfg_length and cfg_decim are latched on the arm cycle.
  - Counters, sts_peak and sts_overflow are cleared.
- ARMED, holdoff phase: each s_axis_tvalid sample increments the holdoff counter and is discarded while counter < latched holdoff.
- ARMED, trigger phase: a valid sample with s_axis_tdata > cfg_level (strict, unsigned) triggers.
  - cfg_level is live, not latched.
  - The triggering sample is the first captured sample. The decimation phase restarts at it.
  - State -> CAPTURE.
- cfg_force in ARMED sets a pending flag. The next valid sample triggers regardless of level and holdoff. The flag clears on trigger or abort.
- CAPTURE: a decimation counter runs 0..cfg_decim on valid samples. A sample is kept when the counter is 0.
  - A kept sample loads the output register if it is empty or being drained in the same cycle.
  - Otherwise the sample is dropped, sts_overflow is set, and it does not count toward length.
- Each loaded sample increments the capture counter. The sample that reaches the latched length is loaded with tlast=1. No further samples are loaded.
- The tlast beat transfers -> DONE, and irq_done pulses.
- sts_peak updates to max(sts_peak, sample) on each loaded sample.
- sts_count increments on each transfer.
- cfg_abort in any state -> IDLE next cycle.
  - m_axis_tvalid is cleared and any pending beat is discarded without tlast. The DMA is reset by software alongside.
  - Status values hold.
- Simultaneous cfg_abort and cfg_arm: abort wins.
- cfg_arm in ARMED or CAPTURE is ignored.
- cfg_force outside ARMED is ignored.
- DONE holds until arm or abort.

## Timing
- Reset values: state IDLE; m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0; sts_peak 0, sts_count 0, sts_overflow 0; irq_done 0.
- Arm at cycle N: sts_state=ARMED at N+1. The sample at N+1 is the first one counted for holdoff.
- Trigger sample valid at cycle N: m_axis_tvalid=1 and sts_state=CAPTURE at N+1.
- Latency from input to output register is 1 cycle. sts_peak updates in the same cycle as the load.
- m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
- A transfer and a new load in the same cycle sustain 1 beat/cycle with no bubble.
- tlast transfer at cycle N: sts_state=DONE and irq_done=1 at N+1. irq_done=0 at N+2.
- Holdoff 0: the first valid sample after arm is eligible to trigger.
- Counters saturate at their maximum and never wrap. A length of 2^CNT_WIDTH−1 is legal.
- areset mid-capture: all outputs return to reset values immediately (asynchronously).

## Test plan
- Basic capture: level=100, holdoff=0, length=4, decim=0, tready=1, ramp input 90..110.
  - First beat is 101; beats 101..104; tlast on 104.
  - irq_done 1 cycle after; sts_count=4, sts_peak=104.
- Holdoff: holdoff=3, level=0, samples 5,6,7,8,9.
  - Samples 5, 6, 7 are discarded; the first beat is 8.
- Decimation and backpressure: decim=2, length=3, input 1..9, tready=1.
  - Beats 1, 4, 7.
  - Repeat with tready held low for 4 cycles: sts_overflow=1, and the beat values skip the dropped samples.
- Force trigger: level=0xFFFF, cfg_force pulsed while ARMED. The next valid sample is captured as the first beat.
- Abort and priority:
  - cfg_abort mid-capture -> IDLE next cycle with tvalid=0 and no tlast.
  - cfg_arm together with cfg_abort in DONE -> IDLE.
- Length 0 and reset: length=0 captures exactly 1 beat with tlast=1. areset asserted mid-capture clears all outputs immediately.

Source files
------------

// File: rtl/adc_capture_ctrl_if.sv
// Stream link used on both sides of the capture controller (ADC in, DMA out).
// Latency: none, wires only.
// Backpressure: tready from the sink; the ADC side never stalls.
// Signals: tvalid/tdata/tlast from the source; tready from the sink.
// Modports:
//   master - drives tvalid/tdata/tlast and samples tready.
//   slave  - samples tvalid/tdata and drives tready.
interface adc_capture_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arm, holdoff, level/forced trigger, decimated capture into a 1-deep output register.
// Latency: 1 cycle from an accepted input sample to m_axis; 1 beat/cycle sustained when the DMA is ready.
// Backpressure: the input cannot be stalled, so a kept sample that finds the output register full is dropped and flagged.
// Ports: aclk/areset; cfg_* from the config bank (arm/abort/force are 1-cycle pulses);
//        s_axis (slave) ADC samples; m_axis (master) captured beats to the DMA;
//        sts_* status bank outputs; irq_done 1-cycle pulse on entry to DONE.
module adc_capture_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_arm,
  input  logic                  cfg_abort,
  input  logic                  cfg_force,
  input  logic [DATA_WIDTH-1:0] cfg_level,
  input  logic [CNT_WIDTH-1:0]  cfg_holdoff,
  input  logic [CNT_WIDTH-1:0]  cfg_length,
  input  logic [7:0]            cfg_decim,
  adc_capture_ctrl_if.slave     s_axis,
  adc_capture_ctrl_if.master    m_axis,
  output logic [1:0]            sts_state,
  output logic [DATA_WIDTH-1:0] sts_peak,
  output logic [CNT_WIDTH-1:0]  sts_count,
  output logic                  sts_overflow,
  output logic                  irq_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  holdoff_lat, length_lat;
  logic [CNT_WIDTH-1:0]  hold_cnt, cap_cnt, cap_inc;
  logic [7:0]            decim_lat, decim_cnt;
  logic                  force_pend;
  logic                  out_vld, out_last;
  logic [DATA_WIDTH-1:0] out_dat;

  logic xfer, keep, hold_done, level_hit;
  logic arm_go, trig, load, drop, irq_nxt;

  assign s_axis.tready = 1'b1;
  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_dat;
  assign m_axis.tlast  = out_last;
  assign sts_state     = state;

  assign xfer      = out_vld & m_axis.tready;
  assign hold_done = (hold_cnt >= holdoff_lat);
  assign level_hit = (s_axis.tdata > cfg_level);
  assign cap_inc   = cap_cnt + CNT_ONE;
  // Once the latched length has been loaded, further kept samples are simply ignored.
  assign keep      = s_axis.tvalid && (decim_cnt == 8'd0) && (cap_cnt < length_lat);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arm_go    = 1'b0;
    trig      = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    irq_nxt   = 1'b0;
    if (cfg_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (cfg_arm) begin
            arm_go    = 1'b1;
            state_nxt = ARMED;
          end
        end
        ARMED: begin
          // A pending force overrides both the holdoff window and the level test.
          if (s_axis.tvalid && (force_pend || (hold_done && level_hit))) begin
            trig      = 1'b1;
            load      = 1'b1;
            state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          if (xfer && out_last) begin
            state_nxt = DONE;
            irq_nxt   = 1'b1;
          end
          // A draining register counts as empty, giving 1 beat/cycle with no bubble.
          if (keep) begin
            if (!out_vld || xfer) load = 1'b1;
            else                  drop = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      holdoff_lat  <= '0;
      length_lat   <= CNT_ONE;
      decim_lat    <= 8'd0;
      hold_cnt     <= '0;
      cap_cnt      <= '0;
      decim_cnt    <= 8'd0;
      force_pend   <= 1'b0;
      out_vld      <= 1'b0;
      out_dat      <= '0;
      out_last     <= 1'b0;
      sts_peak     <= '0;
      sts_count    <= '0;
      sts_overflow <= 1'b0;
      irq_done     <= 1'b0;
    end else begin
      irq_done <= irq_nxt;
      if (cfg_abort) begin
        // Pending beat is thrown away; status registers keep their values.
        out_vld    <= 1'b0;
        out_last   <= 1'b0;
        force_pend <= 1'b0;
      end else begin
        if (arm_go) begin
          holdoff_lat  <= cfg_holdoff;
          length_lat   <= (cfg_length == '0) ? CNT_ONE : cfg_length;
          decim_lat    <= cfg_decim;
          hold_cnt     <= '0;
          cap_cnt      <= '0;
          decim_cnt    <= 8'd0;
          force_pend   <= 1'b0;
          sts_peak     <= '0;
          sts_count    <= '0;
          sts_overflow <= 1'b0;
        end

        if (state == ARMED) begin
          if (cfg_force) force_pend <= 1'b1;
          if (s_axis.tvalid && !hold_done) hold_cnt <= hold_cnt + CNT_ONE;
        end

        // The trigger sample is phase 0 of the decimation cycle.
        if (trig) begin
          force_pend <= 1'b0;
          decim_cnt  <= (decim_lat == 8'd0) ? 8'd0 : 8'd1;
        end else if (state == CAPTURE && s_axis.tvalid) begin
          decim_cnt  <= (decim_cnt == decim_lat) ? 8'd0 : decim_cnt + 8'd1;
        end

        if (xfer) begin
          out_vld  <= 1'b0;
          out_last <= 1'b0;
          if (sts_count != CNT_MAX) sts_count <= sts_count + CNT_ONE;
        end

        if (load) begin
          out_vld  <= 1'b1;
          out_dat  <= s_axis.tdata;
          out_last <= (cap_inc == length_lat);
          cap_cnt  <= cap_inc;
          if (s_axis.tdata > sts_peak) sts_peak <= s_axis.tdata;
        end

        if (drop) sts_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed scenarios, per-cycle comparison against a transaction-level model,
// plus literal expectations for beat sequences and status values.
module tb_adc_capture_ctrl;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  logic        cfg_arm = 0, cfg_abort = 0, cfg_force = 0;
  logic [15:0] cfg_level = 0;
  logic [23:0] cfg_holdoff = 0, cfg_length = 0;
  logic [7:0]  cfg_decim = 0;
  logic [1:0]  sts_state;
  logic [15:0] sts_peak;
  logic [23:0] sts_count;
  logic        sts_overflow, irq_done;

  adc_capture_ctrl_if #(.DATA_WIDTH(16)) s_if ();
  adc_capture_ctrl_if #(.DATA_WIDTH(16)) m_if ();

  adc_capture_ctrl dut (
    .aclk(clk), .areset(areset),
    .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_force(cfg_force),
    .cfg_level(cfg_level), .cfg_holdoff(cfg_holdoff), .cfg_length(cfg_length), .cfg_decim(cfg_decim),
    .s_axis(s_if), .m_axis(m_if),
    .sts_state(sts_state), .sts_peak(sts_peak), .sts_count(sts_count),
    .sts_overflow(sts_overflow), .irq_done(irq_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Output register modelled as a queue of at most one beat; decimation as
  // "sample index since trigger modulo (decim+1)".
  typedef struct packed { logic [15:0] d; logic l; } beat_t;
  beat_t mq[$];
  int    mst = 0;
  int    m_hold = 0, m_len = 1, m_decim = 0, m_seen = 0, m_idx = 0, m_loaded = 0, m_count = 0;
  bit    m_force = 0, m_ovf = 0, m_irq = 0;
  int    m_peak = 0;

  task automatic m_load(input int v);
    beat_t b;
    m_loaded++;
    b.d = 16'(v);
    b.l = (m_loaded == m_len);
    mq.push_back(b);
    if (v > m_peak) m_peak = v;
  endtask

  always @(posedge clk or posedge areset) begin
    bit    xfer;
    beat_t b;
    if (areset) begin
      mst = 0; mq.delete(); m_force = 0; m_peak = 0; m_count = 0; m_ovf = 0; m_irq = 0;
    end else begin
      xfer  = (mq.size() > 0) && m_if.tready;
      m_irq = 0;
      if (cfg_abort) begin
        mst = 0; mq.delete(); m_force = 0;
      end else begin
        case (mst)
          0, 3: if (cfg_arm) begin
            mst = 1; m_hold = int'(cfg_holdoff); m_len = (cfg_length == 0) ? 1 : int'(cfg_length);
            m_decim = int'(cfg_decim); m_seen = 0; m_loaded = 0; m_peak = 0; m_count = 0;
            m_ovf = 0; m_force = 0;
          end
          1: begin
            if (s_if.tvalid) begin
              if (m_force || (m_seen >= m_hold && s_if.tdata > cfg_level)) begin
                mst = 2; m_force = 0; m_load(int'(s_if.tdata)); m_idx = 1;
              end else begin
                m_seen++;
              end
            end
            if (cfg_force && mst == 1) m_force = 1;
          end
          2: begin
            if (xfer) begin
              b = mq.pop_front();
              m_count++;
              if (b.l) begin mst = 3; m_irq = 1; end
            end
            if (s_if.tvalid) begin
              if ((m_idx % (m_decim + 1)) == 0 && m_loaded < m_len) begin
                if (mq.size() == 0) m_load(int'(s_if.tdata));
                else m_ovf = 1;
              end
              m_idx++;
            end
          end
          default: mst = 0;
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  int obs_d[$];
  int obs_l[$];
  int irq_cnt = 0;

  always @(negedge clk) begin
    if (!areset) begin
      chk("state", int'(sts_state), mst);
      chk("tvalid", int'(m_if.tvalid), int'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("tdata", int'(m_if.tdata), int'(mq[0].d));
        chk("tlast", int'(m_if.tlast), int'(mq[0].l));
      end
      chk("peak", int'(sts_peak), m_peak);
      chk("count", int'(sts_count), m_count);
      chk("overflow", int'(sts_overflow), int'(m_ovf));
      chk("irq", int'(irq_done), int'(m_irq));
      if (irq_done) irq_cnt++;
      if (m_if.tvalid && m_if.tready) begin
        obs_d.push_back(int'(m_if.tdata));
        obs_l.push_back(int'(m_if.tlast));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic setcfg(input int lvl, input int hold, input int len, input int dec);
    cfg_level = 16'(lvl); cfg_holdoff = 24'(hold); cfg_length = 24'(len); cfg_decim = 8'(dec);
  endtask

  task automatic arm();
    obs_d.delete(); obs_l.delete(); irq_cnt = 0;
    cfg_arm = 1; step(); cfg_arm = 0;
  endtask

  task automatic feed(input int v);
    s_if.tvalid = 1; s_if.tdata = 16'(v); step(); s_if.tvalid = 0;
  endtask

  task automatic chk_beats(input string nm, input int n, input int d0, input int d1, input int d2, input int d3);
    int e[4];
    e = '{d0, d1, d2, d3};
    chk({nm, "_nbeats"}, obs_d.size(), n);
    for (int i = 0; i < n && i < obs_d.size(); i++) begin
      chk($sformatf("%s_beat%0d", nm, i), obs_d[i], e[i]);
      chk($sformatf("%s_last%0d", nm, i), obs_l[i], int'(i == n - 1));
    end
  endtask

  initial begin
    s_if.tvalid = 0; s_if.tdata = 0; m_if.tready = 1;
    idle(2);
    chk("rst_state", int'(sts_state), 0);
    chk("rst_tvalid", int'(m_if.tvalid), 0);
    chk("rst_tdata", int'(m_if.tdata), 0);
    chk("rst_tlast", int'(m_if.tlast), 0);
    chk("rst_peak", int'(sts_peak), 0);
    chk("rst_count", int'(sts_count), 0);
    chk("rst_ovf", int'(sts_overflow), 0);
    chk("rst_irq", int'(irq_done), 0);
    areset = 0;
    idle(2);

    // Basic capture on a ramp
    setcfg(100, 0, 4, 0); m_if.tready = 1;
    arm();
    chk("s1_armed", int'(sts_state), 1);
    for (int v = 90; v <= 110; v++) feed(v);
    idle(3);
    chk_beats("s1", 4, 101, 102, 103, 104);
    chk("s1_count", int'(sts_count), 4);
    chk("s1_peak", int'(sts_peak), 104);
    chk("s1_irqs", irq_cnt, 1);
    chk("s1_done", int'(sts_state), 3);

    // Holdoff discards the first three samples
    setcfg(0, 3, 2, 0);
    arm();
    for (int v = 5; v <= 9; v++) feed(v);
    idle(3);
    chk_beats("s2", 2, 8, 9, 0, 0);

    // Decimation by 3
    setcfg(0, 0, 3, 2);
    arm();
    for (int v = 1; v <= 9; v++) feed(v);
    idle(3);
    chk_beats("s3", 3, 1, 4, 7, 0);
    chk("s3_ovf", int'(sts_overflow), 0);

    // Decimation with 4 cycles of backpressure: sample 4 is dropped
    arm();
    for (int v = 1; v <= 12; v++) begin
      m_if.tready = !(v >= 2 && v <= 5);
      feed(v);
    end
    m_if.tready = 1;
    idle(3);
    chk_beats("s3b", 3, 1, 7, 10, 0);
    chk("s3b_ovf", int'(sts_overflow), 1);
    chk("s3b_peak", int'(sts_peak), 10);
    chk("s3b_count", int'(sts_count), 3);

    // Forced trigger bypasses an unreachable level and an unfinished holdoff
    setcfg(16'hFFFF, 10, 2, 0);
    arm();
    feed(20); feed(21);
    cfg_force = 1; step(); cfg_force = 0;
    feed(30); feed(31); feed(32);
    idle(3);
    chk_beats("s4", 2, 30, 31, 0, 0);
    chk("s4_done", int'(sts_state), 3);

    // Abort mid-capture with the DMA stalled
    setcfg(0, 0, 10, 0); m_if.tready = 0;
    arm();
    feed(50); feed(51);
    cfg_abort = 1; step(); cfg_abort = 0;
    chk("s5_state", int'(sts_state), 0);
    chk("s5_tvalid", int'(m_if.tvalid), 0);
    chk("s5_tlast", int'(m_if.tlast), 0);
    chk("s5_peak", int'(sts_peak), 50);
    chk("s5_ovf", int'(sts_overflow), 1);
    m_if.tready = 1;
    idle(2);
    chk("s5_nbeats", obs_d.size(), 0);

    // Length 0 captures one beat; then arm+abort together in DONE
    setcfg(0, 0, 0, 0);
    arm();
    feed(77); feed(78);
    idle(3);
    chk_beats("s6", 1, 77, 0, 0, 0);
    chk("s6_done", int'(sts_state), 3);
    cfg_arm = 1; cfg_abort = 1; step(); cfg_arm = 0; cfg_abort = 0;
    chk("s6_abort_wins", int'(sts_state), 0);
    idle(2);

    // Asynchronous reset mid-capture
    setcfg(0, 0, 5, 0); m_if.tready = 0;
    arm();
    feed(33);
    chk("s7_tvalid_before", int'(m_if.tvalid), 1);
    #2 areset = 1;
    #1;
    chk("s7_state", int'(sts_state), 0);
    chk("s7_tvalid", int'(m_if.tvalid), 0);
    chk("s7_tdata", int'(m_if.tdata), 0);
    chk("s7_tlast", int'(m_if.tlast), 0);
    chk("s7_peak", int'(sts_peak), 0);
    chk("s7_count", int'(sts_count), 0);
    chk("s7_ovf", int'(sts_overflow), 0);
    chk("s7_irq", int'(irq_done), 0);
    step();
    areset = 0;
    m_if.tready = 1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
